// File: rtl/i2c_slave_fifo.sv
// i2c_slave_fifo
//   I2C slave with byte-wide receive and transmit FIFOs, masked address
//   match, optional general-call response and automatic clock stretching
//   when the receive FIFO is full or the transmit FIFO is empty.
//
// Ports
//   clk, rst_n            single clock, synchronous active-low reset
//   slave_en              0 = force IDLE, flush both FIFOs, release bus
//   local_addr, addr_mask 7-bit device address; mask bit 1 = compare bit
//   rx_rd_en, rx_data,    host side of the receive FIFO (show-ahead head)
//   rx_empty, rx_level
//   tx_wr_en, tx_data_i,  host side of the transmit FIFO
//   tx_full, tx_level
//   addr_match, gen_call, transfer status (registered)
//   trans_dir
//   get_nack, trans_stop, one-cycle event pulses
//   bus_err
//   stretching            high while this slave holds SCL low
//   scl_i, sda_i          synchronised pad inputs
//   scl_o, sda_o          open-drain drives, 1 = release
//   dbg_state             current FSM state encoding
//
// FIFO handshake: rx_rd_en / tx_wr_en (and the engine's internal push/pop)
// act as valid; ~rx_empty / ~tx_full act as ready. A strobe is accepted in
// a cycle only when its ready is high; a strobe without ready is dropped.
// A push and a pop in the same cycle are both accepted and the level holds.
module i2c_slave_fifo #(
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4,
    parameter bit GC_EN    = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            slave_en,
    input  logic [6:0]                      local_addr,
    input  logic [6:0]                      addr_mask,
    input  logic                            rx_rd_en,
    output logic [7:0]                      rx_data,
    output logic                            rx_empty,
    output logic [$clog2(RX_DEPTH+1)-1:0]   rx_level,
    input  logic                            tx_wr_en,
    input  logic [7:0]                      tx_data_i,
    output logic                            tx_full,
    output logic [$clog2(TX_DEPTH+1)-1:0]   tx_level,
    output logic                            addr_match,
    output logic                            gen_call,
    output logic                            trans_dir,
    output logic                            get_nack,
    output logic                            trans_stop,
    output logic                            bus_err,
    output logic                            stretching,
    input  logic                            scl_i,
    input  logic                            sda_i,
    output logic                            scl_o,
    output logic                            sda_o,
    output logic [3:0]                      dbg_state
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_LW = $clog2(RX_DEPTH + 1);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_LW = $clog2(TX_DEPTH + 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDR       = 4'd1,
        ADDR_ACK   = 4'd2,
        RX_DATA    = 4'd3,
        RX_ACK     = 4'd4,
        STRETCH_RX = 4'd5,
        TX_DATA    = 4'd6,
        TX_ACK     = 4'd7,
        STRETCH_TX = 4'd8,
        WAIT_STOP  = 4'd9
    } state_t;

    state_t      state, state_nxt;
    logic        scl_last, sda_last;
    logic [7:0]  shift, shift_nxt;
    logic [6:0]  tx_sh, tx_sh_nxt;      // remaining bits of the byte being sent
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic        byte_done, byte_done_nxt; // 8th rise of the byte has been seen
    logic        sda_nxt, scl_nxt;
    logic        addr_match_nxt, gen_call_nxt, trans_dir_nxt;
    logic        get_nack_nxt, trans_stop_nxt, bus_err_nxt;
    logic        rx_push, tx_pop, do_load;

    logic        rise, fall, start, stop;
    logic        gc_hit, addr_hit;
    logic        rx_full, tx_empty;
    logic [7:0]  tx_head;

    // ------------------------------------------------------------ edges
    assign rise  = ~scl_last & scl_i;
    assign fall  = scl_last & ~scl_i;
    assign start = slave_en & scl_i & sda_last & ~sda_i;
    assign stop  = slave_en & scl_i & ~sda_last & sda_i;

    assign gc_hit   = GC_EN && (shift == 8'h00);
    assign addr_hit = ((shift[7:1] & addr_mask) == (local_addr & addr_mask)) || gc_hit;

    assign stretching = ~scl_o;
    assign dbg_state  = state;

    // ------------------------------------------------------------ FSM next state
    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift;
        tx_sh_nxt      = tx_sh;
        bit_cnt_nxt    = bit_cnt;
        byte_done_nxt  = byte_done;
        sda_nxt        = sda_o;
        scl_nxt        = scl_o;
        addr_match_nxt = addr_match;
        gen_call_nxt   = gen_call;
        trans_dir_nxt  = trans_dir;
        get_nack_nxt   = 1'b0;
        trans_stop_nxt = 1'b0;
        bus_err_nxt    = 1'b0;
        rx_push        = 1'b0;
        tx_pop         = 1'b0;
        do_load        = 1'b0;

        if (!slave_en) begin
            state_nxt      = IDLE;
            sda_nxt        = 1'b1;
            scl_nxt        = 1'b1;
            bit_cnt_nxt    = 3'd0;
            byte_done_nxt  = 1'b0;
            addr_match_nxt = 1'b0;
            gen_call_nxt   = 1'b0;
            trans_dir_nxt  = 1'b0;
        end else if (start || stop) begin
            // A start/stop part-way through a data byte is a framing error.
            if ((state == RX_DATA || state == TX_DATA) && bit_cnt != 3'd0)
                bus_err_nxt = 1'b1;
            if (stop)
                trans_stop_nxt = addr_match;
            state_nxt      = start ? ADDR : IDLE;
            sda_nxt        = 1'b1;
            scl_nxt        = 1'b1;
            bit_cnt_nxt    = 3'd0;
            byte_done_nxt  = 1'b0;
            addr_match_nxt = 1'b0;
            gen_call_nxt   = 1'b0;
        end else begin
            // Only data-bit clocks are counted; ACK clocks leave the counter at 0.
            if (rise && (state == ADDR || state == RX_DATA || state == TX_DATA)) begin
                shift_nxt   = {shift[6:0], sda_i};
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    byte_done_nxt = 1'b1;
            end

            unique case (state)
                ADDR: begin
                    if (fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        if (addr_hit) begin
                            sda_nxt        = 1'b0;
                            addr_match_nxt = 1'b1;
                            trans_dir_nxt  = shift[0];
                            gen_call_nxt   = gc_hit;
                            state_nxt      = ADDR_ACK;
                        end else begin
                            state_nxt = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (fall) begin
                        if (!trans_dir) begin
                            sda_nxt   = 1'b1;
                            state_nxt = RX_DATA;
                        end else begin
                            do_load = 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        if (!rx_full) begin
                            rx_push   = 1'b1;
                            sda_nxt   = 1'b0;
                            state_nxt = RX_ACK;
                        end else begin
                            scl_nxt   = 1'b0;
                            state_nxt = STRETCH_RX;
                        end
                    end
                end
                STRETCH_RX: begin
                    scl_nxt = 1'b0;
                    if (!rx_full) begin
                        rx_push   = 1'b1;
                        sda_nxt   = 1'b0;
                        scl_nxt   = 1'b1;
                        state_nxt = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (fall) begin
                        sda_nxt   = 1'b1;
                        state_nxt = RX_DATA;
                    end
                end
                TX_DATA: begin
                    if (fall) begin
                        if (byte_done) begin
                            byte_done_nxt = 1'b0;
                            sda_nxt       = 1'b1;
                            state_nxt     = TX_ACK;
                        end else begin
                            sda_nxt   = tx_sh[6];
                            tx_sh_nxt = {tx_sh[5:0], 1'b0};
                        end
                    end
                end
                STRETCH_TX: begin
                    scl_nxt = 1'b0;
                    if (!tx_empty)
                        do_load = 1'b1;
                end
                TX_ACK: begin
                    if (rise && sda_i) begin
                        // Master NACK ends the read; stay off the bus until stop.
                        get_nack_nxt = 1'b1;
                        sda_nxt      = 1'b1;
                        state_nxt    = WAIT_STOP;
                    end else if (fall) begin
                        do_load = 1'b1;
                    end
                end
                WAIT_STOP: begin
                    sda_nxt = 1'b1;
                    scl_nxt = 1'b1;
                end
                default: ;
            endcase

            // Fetch the next byte to send, or hold SCL low until the host supplies one.
            if (do_load) begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    tx_sh_nxt = tx_head[6:0];
                    sda_nxt   = tx_head[7];
                    scl_nxt   = 1'b1;
                    state_nxt = TX_DATA;
                end else begin
                    sda_nxt   = 1'b1;
                    scl_nxt   = 1'b0;
                    state_nxt = STRETCH_TX;
                end
            end
        end
    end

    // ------------------------------------------------------------ FSM registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            scl_last   <= 1'b1;
            sda_last   <= 1'b1;
            shift      <= 8'h00;
            tx_sh      <= 7'h00;
            bit_cnt    <= 3'd0;
            byte_done  <= 1'b0;
            sda_o      <= 1'b1;
            scl_o      <= 1'b1;
            addr_match <= 1'b0;
            gen_call   <= 1'b0;
            trans_dir  <= 1'b0;
            get_nack   <= 1'b0;
            trans_stop <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            scl_last   <= scl_i;
            sda_last   <= sda_i;
            shift      <= shift_nxt;
            tx_sh      <= tx_sh_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_done  <= byte_done_nxt;
            sda_o      <= sda_nxt;
            scl_o      <= scl_nxt;
            addr_match <= addr_match_nxt;
            gen_call   <= gen_call_nxt;
            trans_dir  <= trans_dir_nxt;
            get_nack   <= get_nack_nxt;
            trans_stop <= trans_stop_nxt;
            bus_err    <= bus_err_nxt;
        end
    end

    // ------------------------------------------------------------ receive FIFO
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic             rx_push_ok, rx_pop_ok;

    assign rx_empty   = (rx_level == '0);
    assign rx_full    = (rx_level == RX_LW'(RX_DEPTH));
    assign rx_data    = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
    assign rx_push_ok = rx_push & ~rx_full;
    assign rx_pop_ok  = rx_rd_en & ~rx_empty;

    always_ff @(posedge clk) begin
        if (rx_push_ok)
            rx_mem[rx_wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !slave_en) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (rx_push_ok)
                rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop_ok)
                rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            case ({rx_push_ok, rx_pop_ok})
                2'b10:   rx_level <= rx_level + RX_LW'(1);
                2'b01:   rx_level <= rx_level - RX_LW'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------ transmit FIFO
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic             tx_push_ok, tx_pop_ok;

    assign tx_empty   = (tx_level == '0);
    assign tx_full    = (tx_level == TX_LW'(TX_DEPTH));
    assign tx_head    = tx_mem[tx_rd_ptr];
    assign tx_push_ok = tx_wr_en & ~tx_full;
    assign tx_pop_ok  = tx_pop & ~tx_empty;

    always_ff @(posedge clk) begin
        if (tx_push_ok)
            tx_mem[tx_wr_ptr] <= tx_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !slave_en) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push_ok)
                tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop_ok)
                tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            case ({tx_push_ok, tx_pop_ok})
                2'b10:   tx_level <= tx_level + TX_LW'(1);
                2'b01:   tx_level <= tx_level - TX_LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_fifo.sv
// Directed bench for i2c_slave_fifo: a behavioural I2C master drives the
// wired-AND bus, the host side pushes/pops the FIFOs, and received bytes are
// compared against an expected queue.
module tb_i2c_slave_fifo;

    localparam int Q = 4;   // quarter SCL period in clk cycles

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ADDR       = 4'd1;
    localparam logic [3:0] S_STRETCH_RX = 4'd5;
    localparam logic [3:0] S_STRETCH_TX = 4'd8;
    localparam logic [3:0] S_WAIT_STOP  = 4'd9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       slave_en;
    logic [6:0] local_addr, addr_mask;
    logic       rx_rd_en;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [2:0] rx_level;
    logic       tx_wr_en;
    logic [7:0] tx_data_i;
    logic       tx_full;
    logic [2:0] tx_level;
    logic       addr_match, gen_call, trans_dir;
    logic       get_nack, trans_stop, bus_err, stretching;
    logic       scl_i, sda_i, scl_o, sda_o;
    logic [3:0] dbg_state;

    logic       m_scl, m_sda;
    assign scl_i = m_scl & scl_o;
    assign sda_i = m_sda & sda_o;

    i2c_slave_fifo #(.RX_DEPTH(4), .TX_DEPTH(4), .GC_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .slave_en   (slave_en),
        .local_addr (local_addr),
        .addr_mask  (addr_mask),
        .rx_rd_en   (rx_rd_en),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .rx_level   (rx_level),
        .tx_wr_en   (tx_wr_en),
        .tx_data_i  (tx_data_i),
        .tx_full    (tx_full),
        .tx_level   (tx_level),
        .addr_match (addr_match),
        .gen_call   (gen_call),
        .trans_dir  (trans_dir),
        .get_nack   (get_nack),
        .trans_stop (trans_stop),
        .bus_err    (bus_err),
        .stretching (stretching),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .dbg_state  (dbg_state)
    );

    // ---------------------------------------------------------- clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- pulse monitor
    int stop_cnt = 0;
    int nack_cnt = 0;
    int berr_cnt = 0;

    always @(negedge clk) begin
        if (trans_stop) stop_cnt++;
        if (get_nack)   nack_cnt++;
        if (bus_err)    berr_cnt++;
    end

    // ---------------------------------------------------------- scoreboard
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------- driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        int n;
        n = 0;
        while (scl_i !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (scl_i !== 1'b1)
            check("scl_release_timeout", 32'(scl_i), 1);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        idle(Q);
        m_scl = 1'b1;
        wait_scl_high();
        idle(Q);
        m_sda = 1'b0;
        idle(Q);
        m_scl = 1'b0;
        idle(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        idle(Q);
        m_scl = 1'b1;
        wait_scl_high();
        idle(Q);
        m_sda = 1'b1;
        idle(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;
        idle(Q);
        m_scl = 1'b1;
        wait_scl_high();
        idle(Q);
        m_scl = 1'b0;
        idle(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1;
        idle(Q);
        m_scl = 1'b1;
        wait_scl_high();
        idle(Q / 2);
        b = sda_i;
        idle(Q / 2);
        m_scl = 1'b0;
        idle(Q);
    endtask

    task automatic send_bits(input logic [7:0] d);
        for (int i = 7; i >= 0; i--)
            write_bit(d[i]);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        send_bits(d);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(nack);
    endtask

    task automatic tx_push(input logic [7:0] d);
        tx_data_i = d;
        tx_wr_en  = 1'b1;
        idle(1);
        tx_wr_en  = 1'b0;
    endtask

    task automatic drain_rx(input int n);
        logic [7:0] e;
        check("rx_expected_count", exp_q.size(), n);
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(e));
            rx_rd_en = 1'b1;
            idle(1);
            rx_rd_en = 1'b0;
        end
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        logic       ack;
        logic [7:0] d;
        logic [7:0] e;
        int         base;

        rst_n      = 1'b0;
        slave_en   = 1'b1;
        local_addr = 7'h28;
        addr_mask  = 7'h7F;
        rx_rd_en   = 1'b0;
        tx_wr_en   = 1'b0;
        tx_data_i  = 8'h00;
        m_scl      = 1'b1;
        m_sda      = 1'b1;
        idle(3);

        // Reset values
        check("rst_sda_o", 32'(sda_o), 1);
        check("rst_scl_o", 32'(scl_o), 1);
        check("rst_rx_empty", 32'(rx_empty), 1);
        check("rst_tx_full", 32'(tx_full), 0);
        check("rst_levels", 32'({rx_level, tx_level}), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_flags", 32'({addr_match, gen_call, trans_dir, get_nack,
                                trans_stop, bus_err, stretching}), 0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1'b1;
        idle(3);

        // Exact-address write of two bytes
        i2c_start();
        write_byte(8'h50, ack);
        check("t1_addr_ack", 32'(ack), 0);
        check("t1_addr_match", 32'(addr_match), 1);
        check("t1_trans_dir", 32'(trans_dir), 0);
        check("t1_gen_call", 32'(gen_call), 0);
        write_byte(8'hA5, ack);
        check("t1_ack_a5", 32'(ack), 0);
        exp_q.push_back(8'hA5);
        write_byte(8'h3C, ack);
        check("t1_ack_3c", 32'(ack), 0);
        exp_q.push_back(8'h3C);
        base = stop_cnt;
        i2c_stop();
        idle(2);
        check("t1_trans_stop_pulses", stop_cnt - base, 1);
        check("t1_addr_match_clr", 32'(addr_match), 0);
        check("t1_state_idle", 32'(dbg_state), 32'(S_IDLE));
        check("t1_rx_level", 32'(rx_level), 2);
        drain_rx(2);
        check("t1_rx_empty", 32'(rx_empty), 1);

        // Masked match, then a non-matching address
        addr_mask = 7'h7C;
        i2c_start();
        write_byte(8'h54, ack);
        check("t2_masked_ack", 32'(ack), 0);
        check("t2_masked_match", 32'(addr_match), 1);
        i2c_stop();
        idle(2);
        i2c_start();
        write_byte(8'h60, ack);
        check("t2_nomatch_nack", 32'(ack), 1);
        check("t2_wait_stop", 32'(dbg_state), 32'(S_WAIT_STOP));
        check("t2_sda_released", 32'(sda_o), 1);
        check("t2_no_match", 32'(addr_match), 0);
        i2c_stop();
        idle(2);
        check("t2_idle", 32'(dbg_state), 32'(S_IDLE));
        addr_mask = 7'h7F;

        // RX full -> clock stretch until the host pops
        i2c_start();
        write_byte(8'h50, ack);
        check("t3_addr_ack", 32'(ack), 0);
        for (int i = 1; i <= 4; i++) begin
            d = 8'(i * 8'h11);
            write_byte(d, ack);
            check("t3_data_ack", 32'(ack), 0);
            exp_q.push_back(d);
        end
        send_bits(8'h55);
        idle(8);
        check("t3_scl_held", 32'(scl_o), 0);
        check("t3_stretching", 32'(stretching), 1);
        check("t3_state", 32'(dbg_state), 32'(S_STRETCH_RX));
        check("t3_rx_level_full", 32'(rx_level), 4);
        e = exp_q.pop_front();
        check("t3_rx_head", 32'(rx_data), 32'(e));
        rx_rd_en = 1'b1;
        idle(1);
        rx_rd_en = 1'b0;
        check("t3_level_after_pop", 32'(rx_level), 3);
        check("t3_scl_still_held", 32'(scl_o), 0);
        idle(1);
        check("t3_scl_released", 32'(scl_o), 1);
        check("t3_level_after_push", 32'(rx_level), 4);
        exp_q.push_back(8'h55);
        read_bit(ack);
        check("t3_byte5_ack", 32'(ack), 0);
        i2c_stop();
        idle(2);
        drain_rx(4);

        // Read with preloaded TX FIFO, master NACKs the second byte
        tx_push(8'h81);
        tx_push(8'h7E);
        check("t4_tx_level", 32'(tx_level), 2);
        i2c_start();
        write_byte(8'h51, ack);
        check("t4_addr_ack", 32'(ack), 0);
        check("t4_trans_dir", 32'(trans_dir), 1);
        base = nack_cnt;
        read_byte(1'b0, d);
        check("t4_byte1", 32'(d), 32'h81);
        read_byte(1'b1, d);
        check("t4_byte2", 32'(d), 32'h7E);
        idle(2);
        check("t4_get_nack_pulses", nack_cnt - base, 1);
        check("t4_sda_released", 32'(sda_o), 1);
        check("t4_wait_stop", 32'(dbg_state), 32'(S_WAIT_STOP));
        check("t4_tx_level", 32'(tx_level), 0);
        i2c_stop();
        idle(2);

        // Read with empty TX FIFO -> stretch until the host writes
        i2c_start();
        write_byte(8'h51, ack);
        check("t5_addr_ack", 32'(ack), 0);
        idle(4);
        check("t5_scl_held", 32'(scl_o), 0);
        check("t5_state", 32'(dbg_state), 32'(S_STRETCH_TX));
        tx_data_i = 8'hC3;
        tx_wr_en  = 1'b1;
        idle(1);
        tx_wr_en  = 1'b0;
        check("t5_tx_level_push", 32'(tx_level), 1);
        check("t5_scl_still_held", 32'(scl_o), 0);
        idle(1);
        check("t5_scl_released", 32'(scl_o), 1);
        check("t5_tx_level_pop", 32'(tx_level), 0);
        read_byte(1'b1, d);
        check("t5_byte", 32'(d), 32'hC3);
        i2c_stop();
        idle(2);

        // Repeated start inside a data byte, then general call
        i2c_start();
        write_byte(8'h50, ack);
        check("t6_addr_ack", 32'(ack), 0);
        write_byte(8'h12, ack);
        check("t6_byte1_ack", 32'(ack), 0);
        exp_q.push_back(8'h12);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        base = berr_cnt;
        i2c_start();
        check("t6_bus_err_pulses", berr_cnt - base, 1);
        check("t6_state_addr", 32'(dbg_state), 32'(S_ADDR));
        check("t6_match_cleared", 32'(addr_match), 0);
        write_byte(8'h00, ack);
        check("t6_gc_ack", 32'(ack), 0);
        check("t6_gen_call", 32'(gen_call), 1);
        check("t6_gc_match", 32'(addr_match), 1);
        i2c_stop();
        idle(2);
        check("t6_gen_call_clr", 32'(gen_call), 0);
        check("t6_rx_level", 32'(rx_level), 1);
        drain_rx(1);

        // slave_en low flushes the FIFOs
        tx_push(8'h11);
        tx_push(8'h22);
        check("t7_tx_level", 32'(tx_level), 2);
        slave_en = 1'b0;
        idle(1);
        check("t7_tx_flushed", 32'(tx_level), 0);
        check("t7_state", 32'(dbg_state), 32'(S_IDLE));
        slave_en = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_fifo.md
# i2c_slave_fifo

Parametrised I2C slave with receive and transmit byte FIFOs, masked address match, optional general-call response and automatic clock stretching. It replaces single-register slave buffering: the host drains received bytes and pre-loads transmit bytes through FIFO ports. It sits between the synchronised I2C pad signals and the host register interface. The bit-level engine is self-contained and uses no read/write submodules.

## Interface
- RX_DEPTH, 4, receive FIFO depth in bytes, power of 2, ≥2
- TX_DEPTH, 4, transmit FIFO depth in bytes, power of 2, ≥2
- GC_EN, 1, 1 = ACK general call (address 0x00, write)
- clk  input  1  single clock
- rst_n  input  1  reset, synchronous and active-low
- slave_en  input  1  0 = force IDLE, flush both FIFOs, release bus
- local_addr  input  7  device address
- addr_mask  input  7  bit = 1 compares that address bit; 7'h7F = exact match
- rx_rd_en  input  1  pop rx FIFO
- rx_data  output  8  head of rx FIFO, show-ahead
- rx_empty  output  1  rx FIFO empty
- rx_level  output  $clog2(RX_DEPTH+1)  bytes held in rx FIFO
- tx_wr_en  input  1  push tx_data_i
- tx_data_i  input  8  byte to transmit
- tx_full  output  1  tx FIFO full
- tx_level  output  $clog2(TX_DEPTH+1)  bytes held in tx FIFO
- addr_match  output  1  addressed; high from the address ACK until the next start or stop
- gen_call  output  1  current match came from the general call
- trans_dir  output  1  1 = master reads, 0 = master writes; valid while addr_match
- get_nack  output  1  one-cycle pulse: master NACKed a transmitted byte
- trans_stop  output  1  one-cycle pulse: stop seen while addr_match
- bus_err  output  1  one-cycle pulse: start or stop with bit counter 1..7 in RX_DATA or TX_DATA
- stretching  output  1  equals ~scl_o
- scl_i, sda_i  input  1  externally synchronised
- scl_o, sda_o  output  1  open-drain drive, 1 = release

## Operation
- Edge detection:
  - scl_last and sda_last are registered and reset to 1.
  - rise = ~scl_last & scl_i; fall = scl_last & ~scl_i.
  - start = slave_en & scl_i & sda_last & ~sda_i.
  - stop = slave_en & scl_i & ~sda_last & sda_i.
- Shift register and bit counter: the shift register takes sda_i, MSB first, on each rise. A 3-bit bit counter counts rises and is cleared on start and on each byte boundary.
- Start in any state → ADDR, counter cleared. Stop in any state → IDLE. Start has priority over stop, and both have priority over all other transitions.
- State machine:
  - IDLE: wait for start.
  - ADDR: after the 8th rise, on the next fall:
    - Match when (shift[7:1] & addr_mask) == (local_addr & addr_mask), or when GC_EN, shift == 8'h00 and the R/W bit is 0.
    - On match: sda_o = 0, set addr_match and trans_dir = shift[0], set gen_call if applicable, go to ADDR_ACK.
    - On no match: WAIT_STOP.
  - ADDR_ACK, on fall:
    - Write (trans_dir = 0): release sda, go to RX_DATA.
    - Read (trans_dir = 1): the TX load sequence applies.
  - TX load sequence: if the tx FIFO is non-empty, pop it, drive bit 7, go to TX_DATA. If it is empty, go to STRETCH_TX.
  - RX_DATA: after the 8th rise, on the next fall:
    - rx FIFO not full: push the byte, sda_o = 0, go to RX_ACK.
    - rx FIFO full: go to STRETCH_RX.
  - STRETCH_RX: scl_o = 0. When not full: push, sda_o = 0, scl_o = 1 in the same cycle, go to RX_ACK.
  - RX_ACK: on fall, release sda, go to RX_DATA.
  - TX_DATA: drive the next bit on each fall. On the fall after the 8th rise, release sda and go to TX_ACK.
  - STRETCH_TX: scl_o = 0. When the tx FIFO is non-empty: pop, drive bit 7, release scl, go to TX_DATA.
  - TX_ACK: sample sda_i on rise.
    - 0 (ACK): on fall, run the TX load sequence.
    - 1 (NACK): pulse get_nack, go to WAIT_STOP with sda released.
  - WAIT_STOP: bus released; wait for start or stop.
- FIFO rules:
  - Push when full and pop when empty are ignored.
  - Simultaneous push and pop are both honoured; the level is unchanged.
  - Pointers wrap modulo depth.
- slave_en = 0 clears the state to IDLE, empties both FIFOs, and sets sda_o = scl_o = 1, all on the next clk.

## Timing
- Reset values:
  - state IDLE; sda_o = 1, scl_o = 1.
  - rx_empty = 1, tx_full = 0, levels 0, rx_data = 0.
  - addr_match, gen_call, trans_dir, get_nack, trans_stop, bus_err, stretching all 0.
- All outputs are registered except rx_data (FIFO head), rx_empty, tx_full, levels and stretching, which are combinational from registers.
- The slave updates sda_o one clk after the detected fall, so the SDA change lands within the same SCL low phase.
- Stretch release: scl_o rises one clk after the FIFO condition clears, i.e. one clk after the rx_rd_en or tx_wr_en cycle.
- rx_level increments one clk after the push decision. rx_data shows the new head one clk after rx_rd_en.
- Reset asserted mid-byte: everything returns to reset values at the next clk edge; no partial byte is pushed.

## Test plan
- Master writes 0x50 (local 0x28, mask 0x7F) then 0xA5, 0x3C, stop → two ACKs by slave; rx FIFO holds A5, 3C; trans_dir = 0; trans_stop pulses once.
- Address 0x2A with mask 0x7C, local 0x28 → ACK. Address 0x30 → no ACK, WAIT_STOP, sda_o stays 1.
- RX_DEPTH = 4, master writes 5 bytes, host idle → scl_o held 0 after byte 5; one rx_rd_en releases scl one clk later; byte 5 ACKed and stored.
- Read transfer with tx FIFO holding 0x81, 0x7E → bits driven MSB first. Master ACK, then NACK after byte 2 → get_nack pulses once; sda released.
- Read with empty tx FIFO → stretch after address ACK. tx_wr_en of 0xC3 → scl released next clk; 0xC3 transmitted.
- Repeated start inside byte 2 bit 4 → bus_err pulses, state ADDR. GC_EN = 1 with address 0x00 write → ACK, gen_call = 1.
